// File: rtl/debounce_pkg.sv
// Shared types, defaults and round-robin helpers for the shared-timer button debouncer.
package debounce_pkg;

  localparam int unsigned N_CH_DEF        = 4;
  localparam int unsigned HOLD_CYCLES_DEF = 1000;

  // Widest request vector the arbiter helper can scan.
  localparam int unsigned RR_MAX   = 16;
  localparam int unsigned RR_IDX_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    TIMING = 2'b01,
    CHECK  = 2'b10
  } state_t;

  // First set bit of req at or above ptr, wrapping at n; returns ptr when req is empty.
  function automatic int unsigned rr_pick(input logic [RR_MAX-1:0] req,
                                          input int unsigned       ptr,
                                          input int unsigned       n);
    int unsigned idx;
    int unsigned pick;
    logic        found;
    pick  = ptr;
    found = 1'b0;
    for (int unsigned i = 0; i < RR_MAX; i++) begin
      idx = ptr + i;
      if (idx >= n) idx = idx - n;
      if (!found && (i < n) && req[idx[RR_IDX_W-1:0]]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  // Index following idx, wrapping at n.
  function automatic int unsigned rr_advance(input int unsigned idx,
                                             input int unsigned n);
    return ((idx + 32'd1) >= n) ? 32'd0 : (idx + 32'd1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// One channel: two-flop synchroniser plus delay flop for rising-edge detection.
module edge_sync
  import debounce_pkg::*;
(
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronise the asynchronous pin and keep one cycle of history.
  always_ff @(posedge clock) begin
    if (!reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;

endmodule

// File: rtl/debounce_arbiter.sv
// Debounces N_CH buttons with one shared hold-off timer granted round-robin.
// Define DEBOUNCE_DROP_COUNT_EN to add an 8-bit saturating count of rejected presses (drop_count).
module debounce_arbiter
  import debounce_pkg::*;
#(
  parameter  int unsigned N_CH        = N_CH_DEF,
  parameter  int unsigned HOLD_CYCLES = HOLD_CYCLES_DEF,
  localparam int unsigned CNT_W       = $clog2(HOLD_CYCLES),
  localparam int unsigned ID_W        = $clog2(N_CH)
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [N_CH-1:0] raw,
  output logic [N_CH-1:0] clean,
  output logic            busy,
  output logic [ID_W-1:0] grant_id
`ifdef DEBOUNCE_DROP_COUNT_EN
  ,
  output logic [7:0]      drop_count
`endif
);

  logic [N_CH-1:0]  level;
  logic [N_CH-1:0]  rise;

  state_t           state;
  state_t           state_next;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_next;
  logic [N_CH-1:0]  pending;
  logic [N_CH-1:0]  pending_next;
  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  rr_ptr_next;
  logic [ID_W-1:0]  grant_next;
  logic [ID_W-1:0]  pick;
  logic [N_CH-1:0]  owned_mask;
  logic [N_CH-1:0]  clr_mask;
  logic [N_CH-1:0]  clean_next;
  logic             busy_next;
`ifdef DEBOUNCE_DROP_COUNT_EN
  logic [7:0]       drop_next;
`endif

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    edge_sync u_sync (
      .clock (clock),
      .reset (reset),
      .raw   (raw[g]),
      .level (level[g]),
      .rise  (rise[g])
    );
  end

  // Next-state, arbitration and pending-request bookkeeping.
  always_comb begin
    state_next   = state;
    counter_next = counter;
    grant_next   = grant_id;
    rr_ptr_next  = rr_ptr;
    clean_next   = '0;
    clr_mask     = '0;
`ifdef DEBOUNCE_DROP_COUNT_EN
    drop_next    = drop_count;
`endif
    // The channel under test ignores its own bounces while it owns the timer.
    owned_mask   = (state != IDLE) ? (N_CH'(1) << grant_id) : '0;
    pick         = ID_W'(rr_pick(RR_MAX'(pending), 32'(rr_ptr), N_CH));

    case (state)
      IDLE: begin
        if (|pending) begin
          grant_next   = pick;
          counter_next = '0;
          clr_mask     = N_CH'(1) << pick;
          state_next   = TIMING;
        end
      end
      TIMING: begin
        if (counter == CNT_W'(HOLD_CYCLES - 1)) begin
          state_next = CHECK;
        end else begin
          counter_next = counter + CNT_W'(1);
        end
      end
      CHECK: begin
        if (level[grant_id]) begin
          clean_next = N_CH'(1) << grant_id;
        end else begin
`ifdef DEBOUNCE_DROP_COUNT_EN
          if (drop_count != 8'hFF) drop_next = drop_count + 8'd1;
`endif
        end
        rr_ptr_next = ID_W'(rr_advance(32'(grant_id), N_CH));
        state_next  = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    // Clearing on grant takes priority over a coincident new edge.
    pending_next = (pending | (rise & ~owned_mask)) & ~clr_mask;
    busy_next    = (state_next != IDLE);
  end

  // State and registered outputs.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= IDLE;
      counter  <= '0;
      pending  <= '0;
      rr_ptr   <= '0;
      grant_id <= '0;
      clean    <= '0;
      busy     <= 1'b0;
`ifdef DEBOUNCE_DROP_COUNT_EN
      drop_count <= 8'd0;
`endif
    end else begin
      state    <= state_next;
      counter  <= counter_next;
      pending  <= pending_next;
      rr_ptr   <= rr_ptr_next;
      grant_id <= grant_next;
      clean    <= clean_next;
      busy     <= busy_next;
`ifdef DEBOUNCE_DROP_COUNT_EN
      drop_count <= drop_next;
`endif
    end
  end

endmodule

// File: tb/tb_debounce_arbiter.sv
// Directed bench for debounce_arbiter with N_CH=4, HOLD_CYCLES=8.
// Edge numbers in the vector comments count rising edges after reset release, starting at 0.
module tb_debounce_arbiter;

  localparam int unsigned N = 4;
  localparam int unsigned H = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] raw   = 4'h0;
  logic [3:0] clean;
  logic       busy;
  logic [1:0] grant_id;
`ifdef DEBOUNCE_DROP_COUNT_EN
  logic [7:0] drop_count;
`endif

  debounce_arbiter #(
    .N_CH        (N),
    .HOLD_CYCLES (H)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .raw      (raw),
    .clean    (clean),
    .busy     (busy),
    .grant_id (grant_id)
`ifdef DEBOUNCE_DROP_COUNT_EN
    ,
    .drop_count (drop_count)
`endif
  );

  always #5 clock = ~clock;

  typedef struct {
    int         phase;
    logic       rst;
    logic [3:0] raw;
    int         adv;
    logic [3:0] e_clean;
    logic       e_busy;
    logic [1:0] e_gid;
  } vec_t;

  vec_t vecs[$];

  int         checks = 0;
  int         errors = 0;
  int         pulses[4];
  int         busy_cycles;
  int         multi_hot;
  int         long_pulse;
  logic [3:0] prev_clean;

  function automatic void add(input int p, input logic r, input logic [3:0] rw, input int a,
                              input logic [3:0] ec, input logic eb, input logic [1:0] eg);
    vec_t v;
    v.phase = p; v.rst = r; v.raw = rw; v.adv = a;
    v.e_clean = ec; v.e_busy = eb; v.e_gid = eg;
    vecs.push_back(v);
  endfunction

  task automatic clear_mon();
    for (int i = 0; i < 4; i++) pulses[i] = 0;
    busy_cycles = 0;
    prev_clean  = 4'h0;
  endtask

  // Advance one clock and sample just after the edge; tallies pulse and busy activity.
  task automatic step();
    @(posedge clock);
    #1;
    for (int i = 0; i < 4; i++) begin
      if (clean[i]) pulses[i]++;
      if (clean[i] && prev_clean[i]) long_pulse++;
    end
    if ($countones(clean) > 1) multi_hot++;
    if (busy) busy_cycles++;
    prev_clean = clean;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_phase(input int p);
    foreach (vecs[i]) begin
      if (vecs[i].phase == p) begin
        reset = vecs[i].rst;
        raw   = vecs[i].raw;
        repeat (vecs[i].adv) step();
        check($sformatf("p%0d v%0d clean", p, i), 32'(clean),    32'(vecs[i].e_clean));
        check($sformatf("p%0d v%0d busy",  p, i), 32'(busy),     32'(vecs[i].e_busy));
        check($sformatf("p%0d v%0d gid",   p, i), 32'(grant_id), 32'(vecs[i].e_gid));
        if (!vecs[i].rst) clear_mon();
      end
    end
  endtask

  initial begin
    multi_hot  = 0;
    long_pulse = 0;
    clear_mon();

    // Phase 1: reset with all pins high, then four queued presses served in order.
    add(1, 1'b0, 4'hF,  3, 4'h0, 1'b0, 2'd0);
    add(1, 1'b1, 4'hF,  3, 4'h0, 1'b0, 2'd0); // edges 0-2: pending, still IDLE
    add(1, 1'b1, 4'hF,  1, 4'h0, 1'b1, 2'd0); // edge 3: ch0 granted
    add(1, 1'b1, 4'hF,  8, 4'h0, 1'b1, 2'd0); // edge 11: CHECK
    add(1, 1'b1, 4'hF,  1, 4'h1, 1'b0, 2'd0); // edge 12
    add(1, 1'b1, 4'hF,  1, 4'h0, 1'b1, 2'd1); // edge 13
    add(1, 1'b1, 4'hF,  9, 4'h2, 1'b0, 2'd1); // edge 22
    add(1, 1'b1, 4'hF,  1, 4'h0, 1'b1, 2'd2); // edge 23
    add(1, 1'b1, 4'hF,  9, 4'h4, 1'b0, 2'd2); // edge 32
    add(1, 1'b1, 4'hF, 10, 4'h8, 1'b0, 2'd3); // edge 42
    add(1, 1'b1, 4'hF,  1, 4'h0, 1'b0, 2'd3); // edge 43
    add(1, 1'b1, 4'hF, 20, 4'h0, 1'b0, 2'd3);

    // Phase 2: ch2 held high gives one pulse only.
    add(2, 1'b0, 4'h0,  2, 4'h0, 1'b0, 2'd0);
    add(2, 1'b1, 4'h4, 12, 4'h0, 1'b1, 2'd2); // edge 11
    add(2, 1'b1, 4'h4,  1, 4'h4, 1'b0, 2'd2); // edge 12
    add(2, 1'b1, 4'h4, 40, 4'h0, 1'b0, 2'd2);

    // Phase 3: 3-cycle glitch on ch1 is timed then dropped.
    add(3, 1'b0, 4'h0,  2, 4'h0, 1'b0, 2'd0);
    add(3, 1'b1, 4'h2,  3, 4'h0, 1'b0, 2'd0); // edges 0-2
    add(3, 1'b1, 4'h0,  1, 4'h0, 1'b1, 2'd1); // edge 3
    add(3, 1'b1, 4'h0,  8, 4'h0, 1'b1, 2'd1); // edge 11
    add(3, 1'b1, 4'h0,  1, 4'h0, 1'b0, 2'd1); // edge 12: no pulse
    add(3, 1'b1, 4'h0, 10, 4'h0, 1'b0, 2'd1);

    // Phase 4: ch1 bounces during its own hold-off, ending high.
    add(4, 1'b0, 4'h0,  2, 4'h0, 1'b0, 2'd0);
    add(4, 1'b1, 4'h2,  5, 4'h0, 1'b1, 2'd1); // edges 0-4
    add(4, 1'b1, 4'h0,  1, 4'h0, 1'b1, 2'd1); // edge 5
    add(4, 1'b1, 4'h2,  1, 4'h0, 1'b1, 2'd1); // edge 6
    add(4, 1'b1, 4'h0,  1, 4'h0, 1'b1, 2'd1); // edge 7
    add(4, 1'b1, 4'h2,  5, 4'h2, 1'b0, 2'd1); // edges 8-12
    add(4, 1'b1, 4'h2, 30, 4'h0, 1'b0, 2'd1);

    // Phase 5: after ch3 is served, ch0 and ch3 pend together; ch0 wins, then ch3.
    add(5, 1'b0, 4'h0,  2, 4'h0, 1'b0, 2'd0);
    add(5, 1'b1, 4'h4,  2, 4'h0, 1'b0, 2'd0); // edges 0-1
    add(5, 1'b1, 4'hC, 11, 4'h4, 1'b0, 2'd2); // edges 2-12
    add(5, 1'b1, 4'hC,  1, 4'h0, 1'b1, 2'd3); // edge 13
    add(5, 1'b1, 4'hC,  7, 4'h0, 1'b1, 2'd3); // edge 20
    add(5, 1'b1, 4'h4,  2, 4'h8, 1'b0, 2'd3); // edges 21-22
    add(5, 1'b1, 4'hD,  3, 4'h0, 1'b0, 2'd3); // edges 23-25: both pend at 25
    add(5, 1'b1, 4'hD,  1, 4'h0, 1'b1, 2'd0); // edge 26: ch0 first
    add(5, 1'b1, 4'hD,  9, 4'h1, 1'b0, 2'd0); // edge 35
    add(5, 1'b1, 4'hD,  1, 4'h0, 1'b1, 2'd3); // edge 36
    add(5, 1'b1, 4'hD,  9, 4'h8, 1'b0, 2'd3); // edge 45
    add(5, 1'b1, 4'hD, 10, 4'h0, 1'b0, 2'd3);

    // Phase 6: reset at counter=4 of a ch0 grant, with ch1 also pending.
    add(6, 1'b0, 4'h0,  2, 4'h0, 1'b0, 2'd0);
    add(6, 1'b1, 4'h3,  8, 4'h0, 1'b1, 2'd0); // edges 0-7
    add(6, 1'b0, 4'h0,  2, 4'h0, 1'b0, 2'd0);
    add(6, 1'b1, 4'h0,  1, 4'h0, 1'b0, 2'd0);
    add(6, 1'b1, 4'h0, 30, 4'h0, 1'b0, 2'd0);

    run_phase(1);
    for (int i = 0; i < 4; i++) check($sformatf("p1 pulses ch%0d", i), 32'(pulses[i]), 32'd1);
    check("p1 busy cycles", 32'(busy_cycles), 32'(4 * (H + 1)));

    run_phase(2);
    check("p2 pulses ch2", 32'(pulses[2]), 32'd1);
    check("p2 pulses other", 32'(pulses[0] + pulses[1] + pulses[3]), 32'd0);
    check("p2 busy cycles", 32'(busy_cycles), 32'(H + 1));

    run_phase(3);
    check("p3 pulses", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'd0);
    check("p3 busy cycles", 32'(busy_cycles), 32'(H + 1));
`ifdef DEBOUNCE_DROP_COUNT_EN
    check("p3 drop_count", 32'(drop_count), 32'd1);
`endif

    run_phase(4);
    check("p4 pulses ch1", 32'(pulses[1]), 32'd1);
    check("p4 busy cycles", 32'(busy_cycles), 32'(H + 1));

    run_phase(5);
    check("p5 pulses ch0", 32'(pulses[0]), 32'd1);
    check("p5 pulses ch2", 32'(pulses[2]), 32'd1);
    check("p5 pulses ch3", 32'(pulses[3]), 32'd2);

    run_phase(6);
    check("p6 pulses", 32'(pulses[0] + pulses[1] + pulses[2] + pulses[3]), 32'd0);
    check("p6 busy cycles", 32'(busy_cycles), 32'd0);

    check("clean one-hot", 32'(multi_hot), 32'd0);
    check("clean one cycle", 32'(long_pulse), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
